// File: rtl/uart_tx.sv
// UART transmitter: one-entry holding register feeding a shift-out FSM that
// emits start, data (LSB first), optional parity and stop bits, paced by bit_tick.
module uart_tx #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 bit_tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 txd,
    output logic                 tx_busy,
    output logic                 tx_done
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    state_t                 state;
    logic [2:0]             bit_cnt;
    logic                   stop_cnt;
    logic                   hold_full;
    logic [DATA_BITS-1:0]   hold_data;
    logic [DATA_BITS-1:0]   shifter;
    logic                   parity_bit;
    logic                   accept;
    logic                   stop_last;
    logic                   load;

    function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
        return (^d) ^ (PARITY_ODD != 0);
    endfunction

    assign accept    = tx_valid && tx_ready;
    assign stop_last = (state == STOP) && (stop_cnt == LAST_STOP);
    // A frame is launched from IDLE or chained straight out of the last stop bit.
    assign load      = bit_tick && hold_full && ((state == IDLE) || stop_last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            txd       <= 1'b1;
            tx_ready  <= 1'b1;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
            hold_full <= 1'b0;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
        end else begin
            tx_done <= 1'b0;

            // Accept and load are mutually exclusive: accept needs an empty holder.
            if (accept) begin
                hold_full <= 1'b1;
                tx_ready  <= 1'b0;
            end else if (load) begin
                hold_full <= 1'b0;
                tx_ready  <= 1'b1;
            end

            if (bit_tick) begin
                case (state)
                    IDLE: begin
                        if (hold_full) begin
                            state   <= START;
                            txd     <= 1'b0;
                            tx_busy <= 1'b1;
                        end
                    end
                    START: begin
                        state   <= DATA;
                        txd     <= shifter[0];
                        bit_cnt <= '0;
                    end
                    DATA: begin
                        if (bit_cnt == LAST_BIT) begin
                            if (PARITY_EN != 0) begin
                                state <= PARITY;
                                txd   <= parity_bit;
                            end else begin
                                state    <= STOP;
                                txd      <= 1'b1;
                                stop_cnt <= 1'b0;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            txd     <= shifter[1];
                        end
                    end
                    PARITY: begin
                        state    <= STOP;
                        txd      <= 1'b1;
                        stop_cnt <= 1'b0;
                    end
                    STOP: begin
                        if (stop_cnt == LAST_STOP) begin
                            tx_done <= 1'b1;
                            if (hold_full) begin
                                state <= START;
                                txd   <= 1'b0;
                            end else begin
                                state   <= IDLE;
                                txd     <= 1'b1;
                                tx_busy <= 1'b0;
                            end
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        txd   <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Data path carries no reset; hold_full gates every use of hold_data.
    always_ff @(posedge clk) begin
        if (accept) begin
            hold_data <= tx_data;
        end
        if (load) begin
            shifter    <= hold_data;
            parity_bit <= calc_parity(hold_data);
        end else if ((state == DATA) && bit_tick) begin
            shifter <= shifter >> 1;
        end
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DATA_BITS, default 8, number of data bits per frame, legal range 5..8.
REQ-002 Parameter PARITY_EN, default 1; 1 = parity bit present, 0 = no parity bit.
REQ-003 Parameter PARITY_ODD, default 0; 0 = even parity, 1 = odd parity.
REQ-004 Parameter STOP_BITS, default 1, number of stop bits, legal values 1 or 2.
REQ-005 clk  input  1  system clock; all state changes on its rising edge.
REQ-006 reset  input  1  reset, asynchronous, active-high.
REQ-007 bit_tick  input  1  one-clk-wide enable pulse, once per bit period.
REQ-008 tx_data  input  DATA_BITS  byte to send; bit 0 is sent first.
REQ-009 tx_valid  input  1  tx_data is valid this cycle.
REQ-010 tx_ready  output  1  holding register empty; the block accepts a byte.
REQ-011 txd  output  1  serial line, idle high, registered.
REQ-012 tx_busy  output  1  high from the first start bit to the end of the last stop bit of a frame.
REQ-013 tx_done  output  1  one-clk pulse when the final stop bit of a frame completes.

Function
REQ-014 The block SHALL send this frame, LSB first: start (0), DATA_BITS data bits, parity bit if PARITY_EN, then STOP_BITS stop bits (1).
REQ-015 Parity bit SHALL be the XOR of the data bits, inverted when PARITY_ODD=1.
REQ-016 Handshake: a byte SHALL be accepted at a clk edge where tx_valid && tx_ready; tx_data is copied into a one-entry holding register and tx_ready drops at that edge.
REQ-017 tx_valid while tx_ready=0 SHALL be ignored, with no change to state or held data.
REQ-018 tx_ready SHALL be the inverse of the holding-register-full flag; it is not combinationally dependent on tx_valid.
REQ-019 FSM states: IDLE, START, DATA, PARITY, STOP; transitions only at clk edges with bit_tick=1.
REQ-020 IDLE: on bit_tick with holding register full: move holding register to shifter, free holding register (tx_ready=1 next cycle), go to START, txd<=0.
REQ-021 IDLE with holding register empty SHALL hold txd=1 and ignore bit_tick.
REQ-022 START: on bit_tick, go to DATA, txd<=data bit 0, bit counter<=0.
REQ-023 DATA: on each bit_tick, advance the counter; after bit DATA_BITS-1 has held one period, go to PARITY (txd<=parity) or, if PARITY_EN=0, go to STOP (txd<=1).
REQ-024 PARITY: on bit_tick, go to STOP, txd<=1.
REQ-025 STOP: after STOP_BITS bit periods, pulse tx_done for one clk at the ending bit_tick edge.
REQ-026 At that same edge, if the holding register is full, load the next frame directly into START (txd<=0, no idle gap, tx_busy stays 1); otherwise go to IDLE and drop tx_busy.
REQ-027 Every txd level SHALL last exactly one bit_tick-to-bit_tick interval; a byte accepted mid-frame SHALL NOT disturb the frame in flight.
REQ-028 Parity SHALL be computed from the shifter contents at load, not from the live tx_data.
REQ-029 An accept and a holding-to-shifter move cannot occur on the same edge, because tx_ready=0 while full; no arbitration is required.
REQ-030 tx_busy and tx_ready SHALL both be registered outputs.

Reset
REQ-031 Reset assertion SHALL immediately force txd=1, tx_ready=1, tx_busy=0, tx_done=0, state=IDLE, holding register empty, counters 0.
REQ-032 Reset mid-frame SHALL abort the frame, discard both the in-flight byte and the pending byte, and produce no tx_done.
REQ-033 After deassertion, the first frame SHALL start at the first bit_tick following an accepted byte.

Verification
REQ-034 Defaults, send 0xA5 -> txd per bit period: 0, 1,0,1,0,0,1,0,1, 0 (parity), 1; tx_done pulses once; tx_busy is high for 11 periods.
REQ-035 Back-to-back: 0x00 then 0xFF accepted while the first frame is in flight -> 22 contiguous bit periods with no idle; second frame parity is 0; tx_ready rises at the start bit of frame 2.
REQ-036 PARITY_ODD=1, send 0x01 -> parity bit 0; with 0x03 -> parity bit 1.
REQ-037 PARITY_EN=0, STOP_BITS=2, DATA_BITS=7, send 0x55 -> 0, 1,0,1,0,1,0,1, 1,1; frame is 10 periods long.
REQ-038 Assert reset during data bit 4 with a byte pending -> txd=1 in the same cycle, no tx_done, tx_ready=1; after release, idle until a new byte is accepted.
REQ-039 tx_valid held high with changing tx_data while tx_ready=0 -> transmitted bytes match only the values sampled at accept edges.
